// File: rtl/rf_write_arbiter.sv
// Register file write-port controller: post-reset clear sequencer plus
// writeback / multi-cycle result arbitration with a one-entry hold buffer.
module rf_write_arbiter #(
    parameter int unsigned AWL     = 5,
    parameter int unsigned DWL     = 32,
    parameter int unsigned DEPTH   = 2**AWL,
    parameter int unsigned MAXWAIT = 4
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           WBWE,
    input  logic [AWL-1:0] WBWA,
    input  logic [DWL-1:0] WBWD,
    input  logic           MCV,
    input  logic [AWL-1:0] MCA,
    input  logic [DWL-1:0] MCD,
    output logic           MCRDY,
    output logic           MCDROP,
    output logic           BUSY,
    output logic           STALL,
    output logic           RFWE,
    output logic [AWL-1:0] RFWA,
    output logic [DWL-1:0] RFWD
);

    localparam int unsigned WCW = (MAXWAIT < 1) ? 1 : $clog2(MAXWAIT + 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t         state;
    logic [AWL-1:0] count;
    logic           hv;
    logic [AWL-1:0] ha;
    logic [DWL-1:0] hd;
    logic [WCW-1:0] wc;

    logic wb_req;
    logic hold_go;
    logic wc_inc;

    // Port outputs are combinational so the register file bypass sees the write this cycle.
    always_comb begin
        RFWE    = 1'b0;
        RFWA    = '0;
        RFWD    = '0;
        MCRDY   = 1'b0;
        MCDROP  = 1'b0;
        BUSY    = 1'b0;
        STALL   = 1'b0;
        hold_go = 1'b0;
        wc_inc  = 1'b0;
        wb_req  = WBWE && (WBWA != '0);
        if (RST) begin
            BUSY = 1'b1;
        end else if (state == ST_INIT) begin
            RFWE = 1'b1;
            RFWA = count;
            BUSY = 1'b1;
        end else begin
            MCRDY = !hv;
            if (hv && (wc == WCW'(MAXWAIT))) begin
                STALL   = 1'b1;
                hold_go = 1'b1;
            end else if (wb_req) begin
                RFWE = 1'b1;
                RFWA = WBWA;
                RFWD = WBWD;
                if (hv && (ha == WBWA)) begin
                    MCDROP = 1'b1;
                end else if (hv) begin
                    wc_inc = 1'b1;
                end
            end else if (hv) begin
                hold_go = 1'b1;
            end
            // A hold entry aimed at r0 drains silently in its slot.
            if (hold_go && (ha != '0)) begin
                RFWE = 1'b1;
                RFWA = ha;
                RFWD = hd;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_INIT;
            count <= '0;
            hv    <= 1'b0;
            ha    <= '0;
            hd    <= '0;
            wc    <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    count <= count + AWL'(1);
                    if (count == AWL'(DEPTH - 1)) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (hold_go || MCDROP) begin
                        hv <= 1'b0;
                        wc <= '0;
                    end else if (wc_inc) begin
                        wc <= wc + WCW'(1);
                    end
                    // MCRDY implies hv==0, so accept never collides with a drain.
                    if (MCV && MCRDY) begin
                        hv <= 1'b1;
                        ha <= MCA;
                        hd <= MCD;
                        wc <= '0;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter: init clear, WB pass-through,
// MC drain, starvation forcing, WAW discard and reset during operation.
module tb_rf_write_arbiter;

    localparam int unsigned AWL   = 5;
    localparam int unsigned DWL   = 32;
    localparam int unsigned DEPTH = 32;

    logic           CLK;
    logic           RST;
    logic           WBWE;
    logic [AWL-1:0] WBWA;
    logic [DWL-1:0] WBWD;
    logic           MCV;
    logic [AWL-1:0] MCA;
    logic [DWL-1:0] MCD;
    logic           MCRDY;
    logic           MCDROP;
    logic           BUSY;
    logic           STALL;
    logic           RFWE;
    logic [AWL-1:0] RFWA;
    logic [DWL-1:0] RFWD;

    int errors = 0;
    int checks = 0;

    rf_write_arbiter #(.AWL(AWL), .DWL(DWL), .DEPTH(DEPTH), .MAXWAIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .WBWE(WBWE), .WBWA(WBWA), .WBWD(WBWD),
        .MCV(MCV), .MCA(MCA), .MCD(MCD),
        .MCRDY(MCRDY), .MCDROP(MCDROP), .BUSY(BUSY), .STALL(STALL),
        .RFWE(RFWE), .RFWA(RFWA), .RFWD(RFWD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven and settled before checks.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_rfwe"}, 32'(RFWE), 32'd0);
        chk({tag, "_busy"}, 32'(BUSY), 32'd0);
        chk({tag, "_stall"}, 32'(STALL), 32'd0);
        chk({tag, "_drop"}, 32'(MCDROP), 32'd0);
    endtask

    task automatic check_reset_forced(input string tag);
        settle();
        chk({tag, "_rfwe"}, 32'(RFWE), 32'd0);
        chk({tag, "_mcrdy"}, 32'(MCRDY), 32'd0);
        chk({tag, "_drop"}, 32'(MCDROP), 32'd0);
        chk({tag, "_stall"}, 32'(STALL), 32'd0);
        chk({tag, "_busy"}, 32'(BUSY), 32'd1);
    endtask

    // Checks n consecutive init writes starting at address 0.
    task automatic run_init(input int n);
        for (int i = 0; i < n; i++) begin
            settle();
            chk("init_rfwe", 32'(RFWE), 32'd1);
            chk("init_rfwa", 32'(RFWA), 32'(i));
            chk("init_rfwd", RFWD, 32'd0);
            chk("init_busy", 32'(BUSY), 32'd1);
            chk("init_mcrdy", 32'(MCRDY), 32'd0);
            cyc();
        end
    endtask

    initial begin
        RST = 1'b1; WBWE = 1'b0; WBWA = '0; WBWD = '0;
        MCV = 1'b0; MCA = '0; MCD = '0;
        #1;

        // Reset for two cycles, with WB and MC inputs active to prove they are ignored
        WBWE = 1'b1; WBWA = 5'd4; WBWD = 32'h44; MCV = 1'b1; MCA = 5'd6;
        check_reset_forced("rst0");
        cyc();
        check_reset_forced("rst1");
        cyc();
        RST = 1'b0;
        run_init(DEPTH);
        WBWE = 1'b0; MCV = 1'b0;

        // Cycle 33: RUN, idle
        settle();
        check_idle("run_first");
        chk("run_first_mcrdy", 32'(MCRDY), 32'd1);

        // WB pass-through, same cycle
        WBWE = 1'b1; WBWA = 5'd5; WBWD = 32'hDEADBEEF;
        settle();
        chk("wb_rfwe", 32'(RFWE), 32'd1);
        chk("wb_rfwa", 32'(RFWA), 32'd5);
        chk("wb_rfwd", RFWD, 32'hDEADBEEF);
        chk("wb_stall", 32'(STALL), 32'd0);
        cyc();
        WBWA = 5'd0;
        settle();
        chk("wb_r0_rfwe", 32'(RFWE), 32'd0);
        chk("wb_r0_rfwa", 32'(RFWA), 32'd0);
        cyc();
        WBWE = 1'b0;

        // MC drain in idle slot
        MCV = 1'b1; MCA = 5'd7; MCD = 32'h1234;
        settle();
        chk("mc_acc_mcrdy", 32'(MCRDY), 32'd1);
        chk("mc_acc_rfwe", 32'(RFWE), 32'd0);
        cyc();
        MCV = 1'b0;
        settle();
        chk("mc_drain_mcrdy", 32'(MCRDY), 32'd0);
        chk("mc_drain_rfwe", 32'(RFWE), 32'd1);
        chk("mc_drain_rfwa", 32'(RFWA), 32'd7);
        chk("mc_drain_rfwd", RFWD, 32'h1234);
        cyc();
        settle();
        chk("mc_after_mcrdy", 32'(MCRDY), 32'd1);
        check_idle("mc_after");
        cyc();

        // Starvation: 4 WB writes defer the hold entry, then a forced grant
        MCV = 1'b1; MCA = 5'd9; MCD = 32'h99;
        cyc();
        MCV = 1'b0;
        for (int k = 0; k < 4; k++) begin
            WBWE = 1'b1; WBWA = 5'd3; WBWD = 32'h300 + 32'(k);
            settle();
            chk("starve_wb_rfwa", 32'(RFWA), 32'd3);
            chk("starve_wb_rfwd", RFWD, 32'h300 + 32'(k));
            chk("starve_wb_stall", 32'(STALL), 32'd0);
            chk("starve_wb_mcrdy", 32'(MCRDY), 32'd0);
            cyc();
        end
        WBWD = 32'h3FF;
        settle();
        chk("forced_stall", 32'(STALL), 32'd1);
        chk("forced_rfwe", 32'(RFWE), 32'd1);
        chk("forced_rfwa", 32'(RFWA), 32'd9);
        chk("forced_rfwd", RFWD, 32'h99);
        chk("forced_drop", 32'(MCDROP), 32'd0);
        cyc();
        settle();
        chk("replay_stall", 32'(STALL), 32'd0);
        chk("replay_rfwa", 32'(RFWA), 32'd3);
        chk("replay_rfwd", RFWD, 32'h3FF);
        chk("replay_mcrdy", 32'(MCRDY), 32'd1);
        cyc();
        WBWE = 1'b0;

        // WAW discard: younger WB to the held address supersedes it
        MCV = 1'b1; MCA = 5'd12; MCD = 32'h5555;
        cyc();
        MCV = 1'b0;
        WBWE = 1'b1; WBWA = 5'd12; WBWD = 32'hAA;
        settle();
        chk("waw_rfwa", 32'(RFWA), 32'd12);
        chk("waw_rfwd", RFWD, 32'hAA);
        chk("waw_drop", 32'(MCDROP), 32'd1);
        cyc();
        WBWE = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            check_idle("waw_after");
            chk("waw_after_mcrdy", 32'(MCRDY), 32'd1);
            cyc();
        end

        // Hold entry aimed at r0 drains silently
        MCV = 1'b1; MCA = 5'd0; MCD = 32'hBAD;
        cyc();
        MCV = 1'b0;
        settle();
        check_idle("r0_hold");
        chk("r0_hold_mcrdy", 32'(MCRDY), 32'd0);
        cyc();
        settle();
        chk("r0_after_mcrdy", 32'(MCRDY), 32'd1);
        cyc();

        // Simultaneous MC accept and WB write
        MCV = 1'b1; MCA = 5'd20; MCD = 32'h2020;
        WBWE = 1'b1; WBWA = 5'd21; WBWD = 32'h21;
        settle();
        chk("sim_wb_rfwa", 32'(RFWA), 32'd21);
        chk("sim_wb_rfwd", RFWD, 32'h21);
        cyc();
        MCV = 1'b0; WBWE = 1'b0;
        settle();
        chk("sim_mc_rfwa", 32'(RFWA), 32'd20);
        chk("sim_mc_rfwd", RFWD, 32'h2020);
        cyc();

        // Reset with a live hold entry and a conflicting WB: no drop, hold lost
        MCV = 1'b1; MCA = 5'd15; MCD = 32'hF0F0;
        cyc();
        MCV = 1'b0;
        RST = 1'b1; WBWE = 1'b1; WBWA = 5'd15; WBWD = 32'h77;
        check_reset_forced("rst_hold");
        cyc();
        RST = 1'b0; WBWE = 1'b0;
        run_init(10);

        // Reset at count=10 restarts the clear from address 0
        RST = 1'b1;
        check_reset_forced("rst_mid");
        cyc();
        RST = 1'b0;
        run_init(DEPTH);
        for (int k = 0; k < 6; k++) begin
            settle();
            check_idle("post_init");
            chk("post_init_mcrdy", 32'(MCRDY), 32'd1);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
